// File: rtl/data_sync_multi.sv
// data_sync_multi: multi-channel, enable-qualified bus synchroniser into the CLK domain.
// Optional source-side toggle acknowledge is built when DATA_SYNC_ACK_EN is defined.
module data_sync_multi #(
   parameter int NUM_STAGES = 32'd2,
   parameter int BUS_WIDTH  = 32'd8,
   parameter int NUM_CH     = 32'd2,
   parameter int EDGE_MODE  = 32'd0
) (
   input  logic                          CLK,
   input  logic                          RST_n,
   input  logic [NUM_CH-1:0]             bus_enable,
   input  logic [NUM_CH*BUS_WIDTH-1:0]   UNSYNC_bus,
   input  logic [NUM_CH-1:0]             clr,
   output logic [NUM_CH-1:0]             enable_pulse,
   output logic [NUM_CH*BUS_WIDTH-1:0]   SYNC_bus,
   output logic [NUM_CH-1:0]             sync_valid,
   output logic [NUM_CH-1:0]             overrun,
   output logic [NUM_CH-1:0]             ack
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [NUM_STAGES-1:0] stage_r;
      logic                  q_r;
      logic                  pulse_gen_r;
      logic                  s_s;
      logic                  event_s;
      logic [BUS_WIDTH-1:0]  sync_bus_r;
      logic                  enable_pulse_r;
      logic                  sync_valid_r;
      logic                  overrun_r;
      logic                  sync_valid_nxt_s;
      logic                  overrun_nxt_s;

      assign s_s = stage_r[NUM_STAGES-1];

      if (EDGE_MODE == 32'd0) begin : g_rise
         assign event_s = s_s & ~q_r;
      end else begin : g_any
         assign event_s = s_s ^ q_r;
      end

      // Sticky status: a capture beats clr for valid, clr beats capture for overrun.
      always_comb begin
         sync_valid_nxt_s = sync_valid_r;
         overrun_nxt_s    = overrun_r;
         if (pulse_gen_r) begin
            sync_valid_nxt_s = 1'b1;
         end else if (clr[c]) begin
            sync_valid_nxt_s = 1'b0;
         end else begin
            sync_valid_nxt_s = sync_valid_r;
         end
         if (clr[c]) begin
            overrun_nxt_s = 1'b0;
         end else if (pulse_gen_r && sync_valid_r) begin
            overrun_nxt_s = 1'b1;
         end else begin
            overrun_nxt_s = overrun_r;
         end
      end

      // Enable synchroniser chain, edge detector, data capture and status registers.
      always_ff @(posedge CLK or negedge RST_n) begin
         if (!RST_n) begin
            stage_r        <= '0;
            q_r            <= 1'b0;
            pulse_gen_r    <= 1'b0;
            sync_bus_r     <= '0;
            enable_pulse_r <= 1'b0;
            sync_valid_r   <= 1'b0;
            overrun_r      <= 1'b0;
         end else begin
            stage_r        <= {stage_r[NUM_STAGES-2:0], bus_enable[c]};
            q_r            <= s_s;
            pulse_gen_r    <= event_s;
            enable_pulse_r <= pulse_gen_r;
            sync_valid_r   <= sync_valid_nxt_s;
            overrun_r      <= overrun_nxt_s;
            if (pulse_gen_r) begin
               sync_bus_r <= UNSYNC_bus[c*BUS_WIDTH +: BUS_WIDTH];
            end
         end
      end

      assign enable_pulse[c]                       = enable_pulse_r;
      assign SYNC_bus[c*BUS_WIDTH +: BUS_WIDTH]    = sync_bus_r;
      assign sync_valid[c]                         = sync_valid_r;
      assign overrun[c]                            = overrun_r;

`ifdef DATA_SYNC_ACK_EN
      logic ack_r;

      // Acknowledge toggles on the same edge that raises enable_pulse.
      always_ff @(posedge CLK or negedge RST_n) begin
         if (!RST_n) begin
            ack_r <= 1'b0;
         end else if (pulse_gen_r) begin
            ack_r <= ~ack_r;
         end
      end

      assign ack[c] = ack_r;
`else
      assign ack[c] = 1'b0;
`endif
   end

endmodule
